// File: rtl/div.sv
// div: pipelined restoring unsigned divider, one quotient bit per stage.
// Optional remainder output enabled by defining DIV_REM_EN.
module div #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] quot
`ifdef DIV_REM_EN
    ,
    output logic [DATAWIDTH-1:0] rem
`endif
);

    localparam int N = DATAWIDTH;

    logic w_unused_tail;

    for (genvar g = 0; g < N; g++) begin : g_stg
        logic [N:0]   w_rin;
        logic [N-1:0] w_din;
        logic [N-1:0] w_bin;
        logic [N-1:0] w_qin;
        logic         w_zin;
        logic         w_vin;
        logic [N:0]   w_sh;
        logic [N:0]   w_tr;
        logic [N:0]   w_rout;
        logic [N-1:0] w_qout;
        logic         w_unused;

        if (g == 0) begin : g_in
            assign w_rin = '0;
            assign w_din = a;
            assign w_bin = b;
            assign w_qin = '0;
            assign w_zin = (b == '0);
            assign w_vin = 1'b1;
        end else begin : g_in
            assign w_rin = g_stg[g-1].g_reg.r_rem;
            assign w_din = g_stg[g-1].g_reg.r_dvd;
            assign w_bin = g_stg[g-1].g_reg.r_dvs;
            assign w_qin = g_stg[g-1].g_reg.r_quo;
            assign w_zin = g_stg[g-1].g_reg.r_dz;
            assign w_vin = g_stg[g-1].g_reg.r_vld;
        end

        // Partial remainder never reaches bit N, so bit N of the
        // trial difference is the borrow that decides the quotient bit.
        assign w_sh   = {w_rin[N-1:0], w_din[N-1]};
        assign w_tr   = w_sh - {1'b0, w_bin};
        assign w_rout = w_tr[N] ? w_sh : w_tr;
        assign w_qout = {w_qin[N-2:0], ~w_tr[N]};

        assign w_unused = ^{w_rin[N], w_qin[N-1], w_din[N-2:0]};

        if (g < N - 1) begin : g_reg
            logic [N:0]   r_rem;
            logic [N-1:0] r_dvd;
            logic [N-1:0] r_dvs;
            logic [N-1:0] r_quo;
            logic         r_dz;
            logic         r_vld;

            // Latch this stage's step result for the next stage
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    r_rem <= '0;
                    r_dvd <= '0;
                    r_dvs <= '0;
                    r_quo <= '0;
                    r_dz  <= 1'b0;
                    r_vld <= 1'b0;
                end else begin
                    r_rem <= w_rout;
                    r_dvd <= {w_din[N-2:0], 1'b0};
                    r_dvs <= w_bin;
                    r_quo <= w_qout;
                    r_dz  <= w_zin;
                    r_vld <= w_vin;
                end
            end
        end
    end

    // Final stage feeds the output register; hold when the final stage is empty
    always_ff @(posedge Clk) begin
        if (Rst) begin
            quot <= '0;
        end else if (g_stg[N-1].w_vin) begin
            quot <= g_stg[N-1].w_zin ? '1 : g_stg[N-1].w_qout;
        end
    end

`ifdef DIV_REM_EN
    // Remainder registered alongside the quotient; equals a when b is zero
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rem <= '0;
        end else if (g_stg[N-1].w_vin) begin
            rem <= g_stg[N-1].w_rout[N-1:0];
        end
    end

    assign w_unused_tail = g_stg[N-1].w_rout[N];
`else
    assign w_unused_tail = ^g_stg[N-1].w_rout;
`endif

endmodule

// File: tb/tb_div.sv
// tb_div: scoreboard bench for div at DATAWIDTH 8 and 16.
// Reference results are queued with their due cycle and checked every cycle.
module tb_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  a8  = '0;
    logic [7:0]  b8  = '0;
    logic [7:0]  q8;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic [15:0] q16;
`ifdef DIV_REM_EN
    logic [7:0]  r8;
    logic [15:0] r16;
`endif

    always #5 clk = ~clk;

    div #(.DATAWIDTH(8)) u_div8 (
        .Clk  (clk),
        .Rst  (rst),
        .a    (a8),
        .b    (b8),
`ifdef DIV_REM_EN
        .rem  (r8),
`endif
        .quot (q8)
    );

    div #(.DATAWIDTH(16)) u_div16 (
        .Clk  (clk),
        .Rst  (rst),
        .a    (a16),
        .b    (b16),
`ifdef DIV_REM_EN
        .rem  (r16),
`endif
        .quot (q16)
    );

    typedef struct {
        int unsigned due;
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t        sb8[$];
    exp_t        sb16[$];
    int unsigned cyc   = 0;
    int          tests = 0;
    int          fails = 0;

    // Plain arithmetic reference: all-ones quotient and rem=a for b=0
    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                   input int w, input int unsigned due);
        exp_t        e;
        logic [31:0] m;
        m     = (32'd1 << w) - 32'd1;
        e.due = due;
        if (bv == 32'd0) begin
            e.q = m;
            e.r = av;
        end else begin
            e.q = av / bv;
            e.r = av % bv;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 20)
                $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    // Sampler: every edge either discards in-flight work or queues a result
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                sb8.delete();
                sb16.delete();
                e.due = cyc;
                e.q   = '0;
                e.r   = '0;
                sb8.push_back(e);
                sb16.push_back(e);
            end else begin
                sb8.push_back(model(32'(a8), 32'(b8), 8, cyc + 7));
                sb16.push_back(model(32'(a16), 32'(b16), 16, cyc + 15));
            end
        end
    end

    // Monitor: pop whatever becomes visible this cycle and compare outputs
    initial begin
        exp_t        e;
        logic [31:0] e8q  = '0;
        logic [31:0] e8r  = '0;
        logic [31:0] e16q = '0;
        logic [31:0] e16r = '0;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                while (sb8.size() > 0 && sb8[0].due == cyc) begin
                    e    = sb8.pop_front();
                    e8q  = e.q;
                    e8r  = e.r;
                end
                while (sb16.size() > 0 && sb16[0].due == cyc) begin
                    e    = sb16.pop_front();
                    e16q = e.q;
                    e16r = e.r;
                end
                chk("quot8", 32'(q8), e8q);
                chk("quot16", 32'(q16), e16q);
`ifdef DIV_REM_EN
                chk("rem8", 32'(r8), e8r);
                chk("rem16", 32'(r16), e16r);
`endif
            end
        end
    end

    task automatic drive(input logic rs, input logic [31:0] xa, input logic [31:0] xb,
                         input logic [31:0] ya, input logic [31:0] yb);
        @(negedge clk);
        rst = rs;
        a8  = xa[7:0];
        b8  = xb[7:0];
        a16 = ya[15:0];
        b16 = yb[15:0];
    endtask

    task automatic same(input logic rs, input logic [31:0] x, input logic [31:0] y);
        drive(rs, x, y, x, y);
    endtask

    initial begin
        logic [31:0] xb;
        logic [31:0] yb;
        same(1'b1, 0, 0);
        repeat (10) same(1'b0, 7, 2);
        same(1'b0, 25, 5);
        same(1'b0, 5, 13);
        same(1'b0, 39, 1);
        same(1'b0, 200, 0);
        same(1'b0, 255, 255);
        same(1'b0, 255, 1);
        same(1'b0, 0, 7);
        repeat (3) same(1'b0, 9, 3);
        same(1'b0, 100, 7);
        same(1'b0, 50, 3);
        same(1'b1, 77, 4);
        same(1'b0, 60, 6);
        repeat (20) same(1'b0, 10, 4);
        same(1'b0, 123, 45);
        repeat (4) same(1'b1, 99, 9);
        repeat (20) same(1'b0, 1000, 7);
        repeat (10000) begin
            xb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(0, 255));
            yb = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(0, 65535));
            drive(1'b0, $urandom, xb, $urandom, yb);
        end
        repeat (20) same(1'b0, 1, 1);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
